// File: rtl/ram_turn_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_turn_arbiter_pkg
// Description : Shared phase encoding, read sub-state encoding and default
//               widths for the morse RAM turn arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_turn_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 10;

    // Game phase, also decoded by the hex display and the translator
    localparam logic [1:0] S_START  = 2'd0;
    localparam logic [1:0] S_P1TURN = 2'd1;
    localparam logic [1:0] S_P2TURN = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ADDR = 2'd1;
    localparam logic [1:0] RD_CAPT = 2'd2;
    localparam logic [1:0] RD_ACK  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ram_port_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_seq
// Description : Write/read sequencer and pointer registers for the shared
//               morse RAM. OVERFLOW_WRAP_EN accepts writes while full.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_seq
    import ram_turn_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        i_phase,
    input  logic              i_clear,
    input  logic              i_enter_p2,
    input  logic              i_wr_block,
    input  logic              i_rd_block,
    input  logic              p1_wr_req,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_wr_ack,
    output logic              p1_full,
    input  logic              p2_rd_req,
    output logic              p2_rd_ack,
    output logic [DATA_W-1:0] p2_rd_data,
    output logic              p2_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W:0]   msg_len,
    output logic              o_wr_busy,
    output logic              o_rd_idle
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_rd_state;
    logic [1:0]        w_rd_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_msg_len;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic              r_wr_ack;
    logic              r_rd_ack;
    logic              r_last;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_full;
    logic              w_room;
    logic              w_wr_accept;
    logic              w_rd_accept;

    assign w_full = (r_msg_len == c_DEPTH);

`ifdef OVERFLOW_WRAP_EN
    assign w_room = 1'b1;
`else
    assign w_room = !w_full;
`endif

    // The ack cycle itself blocks a new accept, giving one write per 2 cycles
    assign w_wr_accept = (i_phase == S_P1TURN) && p1_wr_req && !r_wr_ack
                         && !i_wr_block && w_room;
    assign w_rd_accept = (i_phase == S_P2TURN) && p2_rd_req
                         && (r_rd_state == RD_IDLE) && !i_rd_block;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_rd_accept) w_rd_next = RD_ADDR;
            RD_ADDR: w_rd_next = RD_CAPT;
            RD_CAPT: w_rd_next = RD_ACK;
            RD_ACK:  w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            r_msg_len  <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_last     <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ram_wren <= w_wr_accept;
            r_wr_ack   <= w_wr_accept;
            r_rd_ack   <= (r_rd_state == RD_CAPT);
            r_last     <= (r_rd_state == RD_CAPT)
                          && ((r_rd_cnt + (ADDR_W+1)'(1)) == r_msg_len);

            if (w_wr_accept) begin
                r_ram_addr <= r_wr_ptr;
                r_ram_data <= p1_wr_data;
            end else if (w_rd_accept) begin
                r_ram_addr <= r_rd_ptr;
            end

            if (r_wr_ack) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (!w_full) r_msg_len <= r_msg_len + (ADDR_W+1)'(1);
            end

            if (r_rd_state == RD_CAPT) r_rd_data <= ram_q;

            if (r_rd_state == RD_ACK) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
            end

            // Once wrapped, the oldest surviving word sits at the write pointer
            if (i_enter_p2) begin
                r_rd_ptr <= w_full ? r_wr_ptr : '0;
                r_rd_cnt <= '0;
            end

            if (i_clear) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_cnt  <= '0;
                r_msg_len <= '0;
            end
        end
    end

    assign p1_wr_ack  = r_wr_ack;
    assign p1_full    = w_full;
    assign p2_rd_ack  = r_rd_ack;
    assign p2_rd_data = r_rd_data;
    assign p2_last    = r_last;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign ram_wren   = r_ram_wren;
    assign msg_len    = r_msg_len;
    assign o_wr_busy  = w_wr_accept || r_wr_ack;
    assign o_rd_idle  = (r_rd_state == RD_IDLE);

endmodule
`default_nettype wire

// File: rtl/ram_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_turn_arbiter
// Description : Game phase FSM sequencing player1 writes and player2 reads of
//               the shared morse RAM. OVERFLOW_WRAP_EN enables wrap-on-full.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_turn_arbiter
    import ram_turn_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              p1_wr_req,
    input  logic [DATA_W-1:0] p1_wr_data,
    input  logic              p1_done,
    output logic              p1_wr_ack,
    output logic              p1_full,
    input  logic              p2_rd_req,
    input  logic              p2_done,
    output logic              p2_rd_ack,
    output logic [DATA_W-1:0] p2_rd_data,
    output logic              p2_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        phase,
    output logic [ADDR_W:0]   msg_len
);

    logic [1:0] r_phase;
    logic [1:0] w_next_phase;
    logic       r_done_pend;
    logic       w_clear;
    logic       w_enter_p2;
    logic       w_wr_block;
    logic       w_rd_block;
    logic       w_wr_busy;
    logic       w_rd_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= S_START;
        end else begin
            r_phase <= w_next_phase;
        end
    end

    always_comb begin
        w_next_phase = r_phase;
        case (r_phase)
            S_START: begin
                if (start) w_next_phase = S_P1TURN;
            end
            S_P1TURN: begin
                if ((p1_done || r_done_pend) && !w_wr_busy)
                    w_next_phase = (msg_len != '0) ? S_P2TURN : S_RESULT;
            end
            S_P2TURN: begin
                if (p2_rd_ack && p2_last)
                    w_next_phase = S_RESULT;
                else if ((p2_done || r_done_pend) && w_rd_idle)
                    w_next_phase = S_RESULT;
            end
            S_RESULT: begin
                if (start) w_next_phase = S_START;
            end
            default: w_next_phase = S_START;
        endcase
    end

    always_comb begin
        w_clear    = (r_phase == S_START) && start;
        w_enter_p2 = (r_phase == S_P1TURN) && (w_next_phase == S_P2TURN);
        w_wr_block = r_done_pend;
        w_rd_block = r_done_pend || p2_done;
    end

    // A done pulse is remembered until the in-flight transfer has drained
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done_pend <= 1'b0;
        end else if (w_next_phase != r_phase) begin
            r_done_pend <= 1'b0;
        end else if ((r_phase == S_P1TURN) && p1_done) begin
            r_done_pend <= 1'b1;
        end else if ((r_phase == S_P2TURN) && p2_done) begin
            r_done_pend <= 1'b1;
        end
    end

    ram_port_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_seq (
        .clock      (clock),
        .reset      (reset),
        .i_phase    (r_phase),
        .i_clear    (w_clear),
        .i_enter_p2 (w_enter_p2),
        .i_wr_block (w_wr_block),
        .i_rd_block (w_rd_block),
        .p1_wr_req  (p1_wr_req),
        .p1_wr_data (p1_wr_data),
        .p1_wr_ack  (p1_wr_ack),
        .p1_full    (p1_full),
        .p2_rd_req  (p2_rd_req),
        .p2_rd_ack  (p2_rd_ack),
        .p2_rd_data (p2_rd_data),
        .p2_last    (p2_last),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .msg_len    (msg_len),
        .o_wr_busy  (w_wr_busy),
        .o_rd_idle  (w_rd_idle)
    );

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: doc/ram_turn_arbiter.md
Name: ram_turn_arbiter

Overview:
Sequences the shared 16-entry morse RAM (ram32x10) across the game turns.
- Owns the game phase FSM, the write pointer, the read pointer and the stored message length.
- Grants one-at-a-time RAM access: player1 writes during its turn, player2 reads during its turn.
- Drives the RAM address, data and write-enable as registered outputs, so the RAM runs on the system clock and no gated or derived clock is needed.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W
DATA_W, 10, morse word width

Ports:
clock  in  1  system clock (CLOCK_50 domain); also clocks the RAM
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: START->P1TURN, RESULT->START
p1_wr_req  in  1  player1 write request; level, held until p1_wr_ack
p1_wr_data  in  DATA_W  word to store
p1_done  in  1  player1 finished entering the message (pulse)
p1_wr_ack  out  1  write committed this cycle
p1_full  out  1  msg_len == 2**ADDR_W
p2_rd_req  in  1  player2 read request; level, held until p2_rd_ack
p2_done  in  1  player2 abandons the turn (pulse)
p2_rd_ack  out  1  p2_rd_data valid this cycle
p2_rd_data  out  DATA_W  word read back
p2_last  out  1  qualifies p2_rd_ack: this word was the final stored word
ram_addr  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data, valid one cycle after the address is presented
phase  out  2  0=S_START, 1=S_P1TURN, 2=S_P2TURN, 3=S_RESULT
msg_len  out  ADDR_W+1  number of words stored

Behaviour:
- Reset: phase=S_START; wr_ptr, rd_ptr and msg_len = 0; every output 0. A reset mid-transaction aborts it and issues no ack.
- S_START: on start, clear the pointers and msg_len, then go to S_P1TURN. All requests are ignored.
- S_P1TURN write sequence:
  - Cycle N: p1_wr_req=1 with !p1_full.
  - Cycle N+1: ram_wren=1, ram_addr=wr_ptr, ram_data=p1_wr_data (sampled at N), p1_wr_ack=1. wr_ptr and msg_len increment at the end of N+1.
  - Requests seen in the ack cycle are ignored, so at most one write per 2 cycles.
- S_P1TURN, p1_done:
  - The phase changes after any in-flight write acks. If p1_wr_req and p1_done arrive in the same cycle, the write completes first.
  - Next phase is S_P2TURN if msg_len>0, otherwise S_RESULT.
- S_P2TURN read sequence:
  - Cycle N: p2_rd_req=1.
  - Cycle N+1: ram_addr=rd_ptr, ram_wren=0.
  - Cycle N+2: ram_q is captured.
  - Cycle N+3: p2_rd_ack=1 with p2_rd_data, and p2_last=(rd_ptr+1==msg_len). rd_ptr increments at N+3.
  - Read latency is 3 cycles; one read is in flight at a time.
- The read that asserts p2_last moves the phase to S_RESULT at the end of the ack cycle.
- p2_done: go to S_RESULT once any in-flight read has acked.
- S_RESULT: msg_len is held; start returns to S_START.
- ram_wren is only ever 1 in S_P1TURN. p2_rd_req outside S_P2TURN and p1_wr_req outside S_P1TURN are ignored (no ack).
- p2_rd_data holds its last value between acks.
- Full condition: p1_wr_req while p1_full is refused (no ack, no RAM write); see the optional feature for the alternative.
- Empty condition: p2_rd_req with rd_ptr==msg_len cannot occur, because the phase has already left S_P2TURN.

Optional Feature:
OVERFLOW_WRAP_EN
- Defined: a write while full is accepted. wr_ptr wraps to 0 and the oldest word is overwritten. msg_len saturates at 2**ADDR_W. Reads start at the oldest surviving word (rd_ptr initialised to wr_ptr on entry to S_P2TURN).
- Undefined: a write while full is refused as described in Behaviour.

Decomposition:
- Shared package:
  - phase encoding constants S_START/S_P1TURN/S_P2TURN/S_RESULT (shared with hex display logic and the translator)
  - ADDR_W/DATA_W defaults
  - read sub-state encoding RD_IDLE/RD_ADDR/RD_CAPT/RD_ACK
- One natural sub-module: ram_port_seq. It holds the write/read sub-FSM and pointer registers, while the top holds the phase FSM.

Test Plan:
1. Reset high 2 cycles mid-read, then start -> phase=1, msg_len=0, no p2_rd_ack ever emitted.
2. Start; write 0x155, 0x2AA, 0x3FF; p1_done -> ram_wren on 3 cycles with addr 0,1,2, each ack 1 cycle after req; msg_len=3; phase=2.
3. In P2, three reads -> acks 3 cycles after each req with data 0x155, 0x2AA, 0x3FF; p2_last only on the third; phase=3 the next cycle.
4. p1_wr_req and p1_done in the same cycle -> write acked at addr wr_ptr, msg_len incremented, then phase=2.
5. p1_done with msg_len=0 -> phase 1->3 directly; p2_rd_req ignored.
6. 17 writes -> without OVERFLOW_WRAP_EN the 17th gets no ack and p1_full=1; with the macro the 17th writes addr 0, and the first read returns word #2.
